// File: rtl/audio_spi_pkg.sv
// Shared constants for the audio-codec SPI responder: frame layout, RW encoding, FSM states.
package audio_spi_pkg;

    localparam int FRAME_W = 16;
    localparam int RW_BIT  = 8;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/audio_spi_sync_edge.sv
// N-stage synchroniser with rise/fall detect on the synchronised value.
module audio_spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset to the line's idle level so leaving reset never looks like an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/audio_spi_codec_responder.sv
// SPI responder for the audio-codec register protocol with a 128x8 register file.
// Optional bad-frame counter enabled by defining AUDIO_SPI_FRAME_CHK_EN.
module audio_spi_codec_responder
    import audio_spi_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              iCLK_50,
    input  logic              iRESET,
    input  logic              iCS_n,
    input  logic              iSCLK,
    input  logic              iDIN,
    output logic              oDOUT,
    output logic              oDOUT_OE,
    output logic              oWR_VLD,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [DATA_W-1:0] oWR_DATA,
    input  logic [ADDR_W-1:0] iHOST_ADDR,
    output logic [DATA_W-1:0] oHOST_DATA,
    output logic [7:0]        oFRAME_ERR
);

    localparam int FW    = ADDR_W + 1 + DATA_W;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = $clog2(FW + 1);

    localparam logic [CW-1:0] CNT_HDR  = CW'(ADDR_W + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FW);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic din_s;

    audio_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
        .clk_i(iCLK_50), .rst_i(iRESET), .d_i(iSCLK), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    audio_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk_i(iCLK_50), .rst_i(iRESET), .d_i(iCS_n), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    logic unused_sclk_rise;
    assign unused_sclk_rise = sclk_rise;

    always_ff @(posedge iCLK_50 or posedge iRESET) begin
        if (iRESET) din_sync_q <= '0;
        else        din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], iDIN};
    end
    assign din_s = din_sync_q[SYNC_STAGES-1];

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_nxt;
    logic [FW-2:0]     sin_q, sin_d;
    logic [FW-1:0]     sin_nxt;
    logic [DATA_W-1:0] sout_q, sout_d;
    logic              oe_q, oe_d;
    logic              wr_vld_q, wr_vld_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] host_q;
    logic              we;
    logic [DATA_W-1:0] regs_q [DEPTH];

    assign sin_nxt = {sin_q, din_s};
    assign cnt_nxt = cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sin_d     = sin_q;
        sout_d    = sout_q;
        oe_d      = oe_q;
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        we        = 1'b0;
        // CS deassertion takes priority over any coincident SCLK edge.
        if (cs_rise) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            sout_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                        sin_d   = '0;
                        sout_d  = '0;
                        oe_d    = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_fall) begin
                        sin_d  = sin_nxt[FW-2:0];
                        cnt_d  = cnt_nxt;
                        sout_d = {sout_q[DATA_W-2:0], 1'b0};
                        // Header complete on a read: first data bit is driven straight away.
                        if (cnt_nxt == CNT_HDR && sin_nxt[0] == RW_READ)
                            sout_d = regs_q[sin_nxt[ADDR_W:1]];
                        if (cnt_nxt == CNT_FULL) begin
                            state_d = ST_DONE;
                            sout_d  = '0;
                            if (sin_nxt[DATA_W] == RW_WRITE) begin
                                we        = 1'b1;
                                wr_vld_d  = 1'b1;
                                wr_addr_d = sin_nxt[FW-1 -: ADDR_W];
                                wr_data_d = sin_nxt[DATA_W-1:0];
                            end
                        end
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK_50 or posedge iRESET) begin
        if (iRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sin_q     <= '0;
            sout_q    <= '0;
            oe_q      <= 1'b0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            host_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sin_q     <= sin_d;
            sout_q    <= sout_d;
            oe_q      <= oe_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            host_q    <= regs_q[iHOST_ADDR];
        end
    end

    always_ff @(posedge iCLK_50 or posedge iRESET) begin
        if (iRESET) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (we) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

    assign oDOUT      = sout_q[DATA_W-1];
    assign oDOUT_OE   = oe_q;
    assign oWR_VLD    = wr_vld_q;
    assign oWR_ADDR   = wr_addr_q;
    assign oWR_DATA   = wr_data_q;
    assign oHOST_DATA = host_q;

`ifdef AUDIO_SPI_FRAME_CHK_EN
    logic [7:0] err_q;
    logic       done_err_q;
    logic       err_inc, done_hit;

    assign done_hit = !cs_rise && state_q == ST_DONE && sclk_fall && !done_err_q;
    assign err_inc  = (cs_rise && cnt_q != '0 && cnt_q != CNT_FULL) || done_hit;

    always_ff @(posedge iCLK_50 or posedge iRESET) begin
        if (iRESET) begin
            err_q      <= '0;
            done_err_q <= 1'b0;
        end else begin
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
            if (cs_rise)       done_err_q <= 1'b0;
            else if (done_hit) done_err_q <= 1'b1;
        end
    end
    assign oFRAME_ERR = err_q;
`else
    assign oFRAME_ERR = '0;
`endif

endmodule
